// File: rtl/mands_arb.sv
// rtl/mands_arb.sv - round-robin two-requester burst arbiter feeding a max-and-sum unit
// Optional STREAM watchdog enabled by defining MANDS_ARB_TIMEOUT_EN.
module mands_arb #(
    parameter int SETTLE_CYCLES  = 1,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        req0,
    input  logic        req1,
    input  logic [3:0]  len0,
    input  logic [3:0]  len1,
    input  logic [7:0]  din0,
    input  logic [7:0]  din1,
    input  logic        dvalid0,
    input  logic        dvalid1,
    output logic        dready0,
    output logic        dready1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        m_start,
    output logic        m_valid,
    output logic [7:0]  m_data,
    input  logic [7:0]  m_max,
    input  logic [11:0] m_sum,
    output logic [7:0]  res_max,
    output logic [11:0] res_sum,
    output logic        res_id,
    output logic        res_done,
    output logic        res_err,
    output logic        busy
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_STREAM, S_SETTLE, S_DONE} state_t;

    state_t      r_state, w_next;
    logic        r_id, r_ptr;
    logic [3:0]  r_target, r_count;
    logic [2:0]  r_settle;
    logic        r_m_valid;
    logic [7:0]  r_m_data;
    logic [7:0]  r_res_max;
    logic [11:0] r_res_sum;
    logic        r_res_id, r_res_done;
    logic        w_elig0, w_elig1, w_pick, w_accept, w_last, w_settled, w_timeout, w_capture;

    assign w_elig0   = req0 & (len0 != 4'd0);
    assign w_elig1   = req1 & (len1 != 4'd0);
    // r_ptr names the requester that wins the next tie
    assign w_pick    = (w_elig0 & w_elig1) ? r_ptr : w_elig1;
    assign w_accept  = (r_state == S_STREAM) & (r_id ? dvalid1 : dvalid0);
    assign w_last    = w_accept & ((r_count + 4'd1) == r_target);
    assign w_settled = (r_state == S_SETTLE) & (r_settle == 3'(SETTLE_CYCLES));
    assign w_capture = w_settled | w_timeout;

`ifdef MANDS_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_idle;
    logic          r_res_err;

    assign w_timeout = (r_state == S_STREAM) & ~w_accept & (r_idle == TW'(TIMEOUT_CYCLES - 1));
    assign res_err   = r_res_err;

    always_ff @(posedge clk or posedge resetb) begin
        if (resetb) begin
            r_idle    <= '0;
            r_res_err <= 1'b0;
        end else begin
            if (r_state != S_STREAM || w_accept)
                r_idle <= '0;
            else
                r_idle <= r_idle + 1'b1;
            if (w_capture)
                r_res_err <= w_timeout;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign res_err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge resetb) begin
        if (resetb)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_elig0 | w_elig1) w_next = S_START;
            S_START:  w_next = S_STREAM;
            S_STREAM: begin
                if (w_last)
                    w_next = S_SETTLE;
                else if (w_timeout)
                    w_next = S_DONE;
            end
            S_SETTLE: if (w_settled) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge resetb) begin
        if (resetb) begin
            r_id       <= 1'b0;
            r_ptr      <= 1'b0;
            r_target   <= 4'd0;
            r_count    <= 4'd0;
            r_settle   <= 3'd0;
            r_m_valid  <= 1'b0;
            r_m_data   <= 8'd0;
            r_res_max  <= 8'd0;
            r_res_sum  <= 12'd0;
            r_res_id   <= 1'b0;
            r_res_done <= 1'b0;
        end else begin
            if (r_state == S_IDLE && (w_elig0 | w_elig1))
                r_id <= w_pick;
            if (r_state == S_START) begin
                r_target <= r_id ? len1 : len0;
                r_count  <= 4'd0;
            end else if (w_accept) begin
                r_count <= r_count + 4'd1;
            end
            r_m_valid <= w_accept;
            if (w_accept)
                r_m_data <= r_id ? din1 : din0;
            // SETTLE's first cycle carries the last m_valid, so the wait starts there
            if (r_state == S_SETTLE)
                r_settle <= r_settle + 3'd1;
            else
                r_settle <= 3'd0;
            r_res_done <= w_capture;
            if (w_capture) begin
                r_res_max <= m_max;
                r_res_sum <= m_sum;
                r_res_id  <= r_id;
            end
            if (r_state == S_DONE)
                r_ptr <= ~r_id;
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign gnt0     = busy & ~r_id;
    assign gnt1     = busy & r_id;
    assign m_start  = (r_state == S_START);
    assign dready0  = (r_state == S_STREAM) & ~r_id;
    assign dready1  = (r_state == S_STREAM) & r_id;
    assign m_valid  = r_m_valid;
    assign m_data   = r_m_data;
    assign res_max  = r_res_max;
    assign res_sum  = r_res_sum;
    assign res_id   = r_res_id;
    assign res_done = r_res_done;
endmodule

// File: tb/tb_mands_arb.sv
// tb/tb_mands_arb.sv - self-checking bench for mands_arb with a behavioural max-and-sum stand-in
module tb_mands_arb;
    logic        clk = 1'b0;
    logic        resetb = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [3:0]  len0 = 4'd0, len1 = 4'd0;
    logic [7:0]  din0 = 8'd0, din1 = 8'd0;
    logic        dvalid0 = 1'b0, dvalid1 = 1'b0;
    logic        dready0, dready1, gnt0, gnt1, m_start, m_valid;
    logic [7:0]  m_data;
    logic [7:0]  m_max = 8'd0;
    logic [11:0] m_sum = 12'd0;
    logic [7:0]  res_max;
    logic [11:0] res_sum;
    logic        res_id, res_done, res_err, busy;

    int checks = 0;
    int failures = 0;
    int n_start = 0, n_valid = 0, n_done = 0, n_overlap = 0, cyc = 0;
    int rx_q[$];
    int vcyc_q[$];
    int cur[15];

    typedef struct {
        bit id;
        int len;
        int ga;
        int gl;
        int emax;
        int esum;
    } vec_t;

    always #5 clk = ~clk;

    mands_arb #(.SETTLE_CYCLES(1), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .resetb(resetb),
        .req0(req0), .req1(req1), .len0(len0), .len1(len1),
        .din0(din0), .din1(din1), .dvalid0(dvalid0), .dvalid1(dvalid1),
        .dready0(dready0), .dready1(dready1), .gnt0(gnt0), .gnt1(gnt1),
        .m_start(m_start), .m_valid(m_valid), .m_data(m_data),
        .m_max(m_max), .m_sum(m_sum),
        .res_max(res_max), .res_sum(res_sum), .res_id(res_id),
        .res_done(res_done), .res_err(res_err), .busy(busy)
    );

    // External max-and-sum unit as seen by the arbiter
    always @(posedge clk) begin
        if (m_start) begin
            m_max <= 8'h80;
            m_sum <= 12'd0;
        end else if (m_valid) begin
            if ($signed(m_data) > $signed(m_max)) m_max <= m_data;
            m_sum <= m_sum + {{4{m_data[7]}}, m_data};
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (m_start) n_start++;
        if (m_start && m_valid) n_overlap++;
        if (m_valid) begin
            n_valid++;
            rx_q.push_back(int'(m_data));
            vcyc_q.push_back(cyc);
        end
        if (res_done) n_done++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int s8(input int x);
        int v;
        v = x & 255;
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic int mdl_max(input int n);
        int m;
        m = s8(cur[0]);
        for (int i = 1; i < n; i++) if (s8(cur[i]) > m) m = s8(cur[i]);
        return m & 255;
    endfunction

    function automatic int mdl_sum(input int n);
        int s;
        s = 0;
        for (int i = 0; i < n; i++) s += s8(cur[i]);
        return ((s % 4096) + 4096) % 4096;
    endfunction

    function automatic logic [63:0] outs();
        return 64'({dready0, dready1, gnt0, gnt1, m_start, m_valid, m_data,
                    res_max, res_sum, res_id, res_done, res_err, busy});
    endfunction

    task automatic clear_mon();
        @(negedge clk);
        n_start = 0;
        n_valid = 0;
        n_done = 0;
        rx_q.delete();
        vcyc_q.delete();
    endtask

    task automatic wait_grant(output int who);
        who = -1;
        for (int t = 0; t < 20 && who < 0; t++) begin
            @(negedge clk);
            if (gnt0) who = 0;
            else if (gnt1) who = 1;
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (res_done) ok = 1'b1;
        end
    endtask

    task automatic stream(input bit id, input int n_send, input int ga, input int gl, output bit ok);
        int i;
        int gleft;
        int t;
        i = 0;
        gleft = gl;
        t = 0;
        ok = 1'b1;
        while (i < n_send) begin
            @(negedge clk);
            t++;
            if (t > 200) begin
                ok = 1'b0;
                break;
            end
            if (i == ga && gleft > 0) begin
                dvalid0 = 1'b0;
                dvalid1 = 1'b0;
                gleft--;
            end else begin
                if (id) begin dvalid1 = 1'b1; din1 = 8'(cur[i]); end
                else    begin dvalid0 = 1'b1; din0 = 8'(cur[i]); end
                if (id ? dready1 : dready0) i++;
            end
        end
        @(negedge clk);
        dvalid0 = 1'b0;
        dvalid1 = 1'b0;
    endtask

    task automatic serve(input string tag, input bit exp_id, input int n, input int ga, input int gl,
                         input int emax, input int esum);
        int who;
        bit ok;
        bit id;
        int bad;
        wait_grant(who);
        chk({tag, " grant_id"}, 64'(who), 64'(exp_id));
        id = (who < 0) ? exp_id : who[0];
        if (id) req1 = 1'b0; else req0 = 1'b0;
        stream(id, n, ga, gl, ok);
        chk({tag, " stream_complete"}, 64'(ok), 64'd1);
        wait_done(ok);
        chk({tag, " res_done_seen"}, 64'(ok), 64'd1);
        chk({tag, " m_start_count"}, 64'(n_start), 64'd1);
        chk({tag, " m_valid_count"}, 64'(n_valid), 64'(n));
        bad = 0;
        for (int i = 0; i < n; i++)
            if (i >= rx_q.size() || rx_q[i] != (cur[i] & 255)) bad++;
        chk({tag, " m_data_seq_errors"}, 64'(bad), 64'd0);
        if (gl > 0 && ga > 0 && vcyc_q.size() > ga)
            chk({tag, " gap_mirror"}, 64'(vcyc_q[ga] - vcyc_q[ga-1]), 64'(gl + 1));
        chk({tag, " res_max"}, 64'(res_max), 64'(emax & 255));
        chk({tag, " res_sum"}, 64'(res_sum), 64'(esum & 4095));
        chk({tag, " res_id"}, 64'(res_id), 64'(exp_id));
        chk({tag, " res_err"}, 64'(res_err), 64'd0);
    endtask

    initial begin
        vec_t vt[4];
        int   vs[4][15];
        int   who;
        bit   ok;
        int   cnt;
        int   rid, rn, rga, rgl;

        vt[0] = '{1'b0, 9, 0, 0, 7, 3};
        vs[0] = '{-5, -2, 3, 1, 7, 0, 1, -5, 3, 0, 0, 0, 0, 0, 0};
        vt[1] = '{1'b1, 3, 1, 2, 5, 'hFED};
        vs[1] = '{-1, 5, 233, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[2] = '{1'b0, 1, 0, 0, 127, 127};
        vs[2] = '{127, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vt[3] = '{1'b1, 15, 7, 1, 'h80, 'h880};
        for (int i = 0; i < 15; i++) vs[3][i] = -128;

        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 64'd0);
        resetb = 1'b0;
        @(negedge clk);
        chk("idle_outputs", outs(), 64'd0);

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 15; i++) cur[i] = vs[k][i];
            clear_mon();
            if (vt[k].id) begin req1 = 1'b1; len1 = 4'(vt[k].len); end
            else          begin req0 = 1'b1; len0 = 4'(vt[k].len); end
            serve($sformatf("vec%0d", k), vt[k].id, vt[k].len, vt[k].ga, vt[k].gl, vt[k].emax, vt[k].esum);
        end

        // Round-robin: tie after reset serves 0 then 1; after a solo 0 burst a tie serves 1 first
        for (int i = 0; i < 15; i++) cur[i] = int'($urandom_range(0, 255));
        clear_mon();
        len0 = 4'd3; len1 = 4'd3; req0 = 1'b1; req1 = 1'b1;
        serve("tie_a_first", 1'b0, 3, 0, 0, mdl_max(3), mdl_sum(3));
        clear_mon();
        serve("tie_a_second", 1'b1, 3, 0, 0, mdl_max(3), mdl_sum(3));
        clear_mon();
        len0 = 4'd1; req0 = 1'b1;
        serve("solo0", 1'b0, 1, 0, 0, mdl_max(1), mdl_sum(1));
        clear_mon();
        len0 = 4'd3; req0 = 1'b1; req1 = 1'b1;
        serve("tie_b_first", 1'b1, 3, 0, 0, mdl_max(3), mdl_sum(3));
        clear_mon();
        serve("tie_b_second", 1'b0, 3, 0, 0, mdl_max(3), mdl_sum(3));

        // Reset after the 4th of 9 samples
        for (int i = 0; i < 15; i++) cur[i] = vs[0][i];
        clear_mon();
        req0 = 1'b1; len0 = 4'd9;
        wait_grant(who);
        chk("midrst_grant", 64'(who), 64'd0);
        req0 = 1'b0;
        stream(1'b0, 4, 0, 0, ok);
        resetb = 1'b1;
        @(negedge clk);
        chk("midrst_outputs", outs(), 64'd0);
        resetb = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_no_done", 64'(n_done), 64'd0);
        clear_mon();
        len0 = 4'd9; len1 = 4'd3; req0 = 1'b1; req1 = 1'b1;
        serve("postrst_first", 1'b0, 9, 0, 0, 7, 3);
        clear_mon();
        serve("postrst_second", 1'b1, 3, 0, 0, mdl_max(3), mdl_sum(3));

        // len = 0 is never granted
        req0 = 1'b1; len0 = 4'd0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || gnt0) cnt++;
        end
        chk("len0_zero_busy_cycles", 64'(cnt), 64'd0);
        req0 = 1'b0;

        // Burst starved after 2 of 5 samples
        for (int i = 0; i < 15; i++) cur[i] = int'($urandom_range(0, 255));
        clear_mon();
        req0 = 1'b1; len0 = 4'd5;
        wait_grant(who);
        chk("starve_grant", 64'(who), 64'd0);
        req0 = 1'b0;
        stream(1'b0, 2, 0, 0, ok);
        chk("starve_stream", 64'(ok), 64'd1);
`ifdef MANDS_ARB_TIMEOUT_EN
        wait_done(ok);
        chk("starve_done_seen", 64'(ok), 64'd1);
        chk("starve_err", 64'(res_err), 64'd1);
        chk("starve_max", 64'(res_max), 64'(mdl_max(2)));
        chk("starve_sum", 64'(res_sum), 64'(mdl_sum(2)));
        chk("starve_id", 64'(res_id), 64'd0);
        @(negedge clk);
`else
        repeat (40) @(negedge clk);
        chk("starve_still_busy", 64'(busy), 64'd1);
        chk("starve_no_done", 64'(n_done), 64'd0);
        resetb = 1'b1;
        @(negedge clk);
        resetb = 1'b0;
        @(negedge clk);
`endif

        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 15; i++) cur[i] = int'($urandom_range(0, 255));
            rid = int'($urandom_range(0, 1));
            rn  = int'($urandom_range(1, 15));
            rga = (rn > 1) ? int'($urandom_range(1, rn - 1)) : 0;
            rgl = int'($urandom_range(0, 3));
            clear_mon();
            if (rid == 1) begin req1 = 1'b1; len1 = 4'(rn); end
            else          begin req0 = 1'b1; len0 = 4'(rn); end
            serve($sformatf("rnd%0d", k), rid[0], rn, rga, rgl, mdl_max(rn), mdl_sum(rn));
        end

        chk("start_valid_overlap", 64'(n_overlap), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
